// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: PLL RST driver, LOCKED synchroniser and stable-lock system reset release.
// Define PLL_LOSS_CNT_EN to add the saturating lock-loss counter output loss_cnt.
module pll_lock_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 17
) (
    input  logic       clk,
    input  logic       cpu_reset_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       locked_sync,
    output logic       sys_rst_n,
    output logic       ready
`ifdef PLL_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    typedef enum logic [1:0] {
        PLLRST,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    localparam longint CNT_RANGE = longint'(1) << CNT_W;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 1) begin : g_bad_min
        $error("cycle parameters below their minimum");
    end
    if (PLL_RST_CYCLES > CNT_RANGE || LOCK_TIMEOUT > CNT_RANGE
        || STABLE_CYCLES > CNT_RANGE) begin : g_bad_cnt_w
        $error("CNT_W too narrow for cycle parameters");
    end

    logic [1:0]             rst_sync_q;
    logic [SYNC_STAGES-1:0] lsync_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pll_rst_q;
    logic                   sys_rst_n_q;
    logic                   ready_q;
    logic                   run_en;

    assign run_en      = rst_sync_q[1];
    assign locked_sync = lsync_q[SYNC_STAGES-1];
    assign pll_rst     = pll_rst_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign ready       = ready_q;

    // Release of cpu_reset_n is re-timed so the FSM leaves reset cleanly.
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            rst_sync_q <= '0;
            lsync_q    <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            lsync_q    <= {lsync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (run_en) begin
            unique case (state_q)
                PLLRST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_sync) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = PLLRST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                STABLE: begin
                    // A lock glitch restarts the wait without pulsing RST.
                    if (!locked_sync) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    cnt_d = '0;
                    if (!locked_sync) begin
                        state_d = PLLRST;
                    end
                end
                default: begin
                    state_d = PLLRST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state_q     <= PLLRST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= (state_d == PLLRST);
            sys_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
        end
    end

`ifdef PLL_LOSS_CNT_EN
    logic [7:0] loss_q;
    logic       loss_ev;

    // PLLRST is only re-entered on lock loss or lock timeout.
    assign loss_ev  = (state_d == PLLRST) && (state_q != PLLRST);
    assign loss_cnt = loss_q;

    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            loss_q <= '0;
        end else if (loss_ev && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end
`endif

endmodule
